pak_dump_sequencer: RTL and testbench

Command sequencer between the UART receiver and the GBA cartridge read engine. It decodes single-byte dump commands and a multi-byte ranged-read command, then launches one read burst with an explicit word address and count. It waits for the engine to finish and returns a one-byte status over a UART transmit port that it owns only between bursts. An inter-byte timeout recovers from truncated commands.

---
 rtl/pak_dump_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_pak_dump_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pak_dump_sequencer.sv
// Dump command sequencer: decodes UART commands, launches one read burst, returns a status byte.
// Optional feature macro PAK_ABORT_EN: `x` during a burst aborts the reader and returns `A`.

module pak_dump_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2700000,
    parameter int unsigned HEADER_WORDS   = 96
) (
    input  logic        pin_clk,
    input  logic        pin_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        reader_start,
    output logic [23:0] reader_addr,
    output logic [23:0] reader_count,
    input  logic        reader_done,
    output logic        reader_abort,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_ready,
    output logic        tx_owner,
    output logic        busy
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] CMD_HEADER = 8'h68;  // 'h'
    localparam logic [7:0] CMD_4MB    = 8'h61;  // 'a'
    localparam logic [7:0] CMD_8MB    = 8'h62;  // 'b'
    localparam logic [7:0] CMD_16MB   = 8'h63;  // 'c'
    localparam logic [7:0] CMD_32MB   = 8'h64;  // 'd'
    localparam logic [7:0] CMD_RANGE  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_STATUS = 8'h3F;  // '?'

    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERROR   = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'
    localparam logic [7:0] RSP_DONE    = 8'h44;  // 'D'

    localparam logic [2:0] ARG_BYTES = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e               state_q,    state_d;
    logic [23:0]          addr_q,     addr_d;
    logic [23:0]          count_q,    count_d;
    logic [47:0]          args_q,     args_d;
    logic [2:0]           arg_cnt_q,  arg_cnt_d;
    logic [TIMER_W-1:0]   timer_q,    timer_d;
    logic [7:0]           status_q,   status_d;
    logic [7:0]           tx_data_q,  tx_data_d;
    logic                 tx_send_q,  tx_send_d;
    logic                 tx_owner_q, tx_owner_d;
`ifdef PAK_ABORT_EN
    localparam logic [7:0] CMD_ABORT = 8'h78;  // 'x'
    localparam logic [7:0] RSP_ABORT = 8'h41;  // 'A'
    logic                 abort_q,    abort_d;
`endif

    // A ranged read may end exactly at the top of the 24-bit word space but not past it.
    logic [24:0] range_end;
    logic        range_bad;

    assign range_end = {1'b0, args_q[47:24]} + {1'b0, args_q[23:0]};
    assign range_bad = (args_q[23:0] == 24'd0) || (range_end > 25'h100_0000);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        args_d     = args_q;
        arg_cnt_d  = arg_cnt_q;
        timer_d    = timer_q;
        status_d   = status_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        tx_owner_d = tx_owner_q;
`ifdef PAK_ABORT_EN
        abort_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_HEADER: begin
                            addr_d  = 24'd0;
                            count_d = 24'(HEADER_WORDS);
                            state_d = S_LAUNCH;
                        end
                        CMD_4MB: begin
                            addr_d  = 24'd0;
                            count_d = 24'h20_0000;
                            state_d = S_LAUNCH;
                        end
                        CMD_8MB: begin
                            addr_d  = 24'd0;
                            count_d = 24'h40_0000;
                            state_d = S_LAUNCH;
                        end
                        CMD_16MB: begin
                            addr_d  = 24'd0;
                            count_d = 24'h80_0000;
                            state_d = S_LAUNCH;
                        end
                        CMD_32MB: begin
                            // 32 MB needs 2^24 words; the count field saturates one word short.
                            addr_d  = 24'd0;
                            count_d = 24'hFF_FFFF;
                            state_d = S_LAUNCH;
                        end
                        CMD_RANGE: begin
                            arg_cnt_d = 3'd0;
                            timer_d   = '0;
                            state_d   = S_ARGS;
                        end
                        CMD_STATUS: begin
                            status_d = RSP_OK;
                            state_d  = S_RESP;
                        end
                        default: ;
                    endcase
                end
            end

            S_ARGS: begin
                if (arg_cnt_q == ARG_BYTES) begin
                    timer_d = '0;
                    if (range_bad) begin
                        status_d = RSP_ERROR;
                        state_d  = S_RESP;
                    end else begin
                        addr_d  = args_q[47:24];
                        count_d = args_q[23:0];
                        state_d = S_LAUNCH;
                    end
                end else if (rx_valid) begin
                    // A byte landing on the timeout cycle still counts and restarts the timer.
                    args_d    = {args_q[39:0], rx_data};
                    arg_cnt_d = arg_cnt_q + 3'd1;
                    timer_d   = '0;
                end else if (timer_q == TIMEOUT_VAL) begin
                    timer_d  = '0;
                    status_d = RSP_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_LAUNCH: begin
                tx_owner_d = 1'b0;
                state_d    = S_WAIT;
            end

            S_WAIT: begin
                if (reader_done) begin
                    tx_owner_d = 1'b1;
                    status_d   = RSP_DONE;
                    state_d    = S_RESP;
`ifdef PAK_ABORT_EN
                end else if (rx_valid && (rx_data == CMD_ABORT)) begin
                    abort_d    = 1'b1;
                    tx_owner_d = 1'b1;
                    status_d   = RSP_ABORT;
                    state_d    = S_RESP;
`endif
                end
            end

            S_RESP: begin
                tx_owner_d = 1'b1;
                if (tx_ready) begin
                    tx_data_d = status_q;
                    tx_send_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pin_clk) begin
        if (!pin_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 24'd0;
            count_q    <= 24'd0;
            // NOTE: the argument shift register is plain datapath and is reset only for deterministic lint/sim.
            args_q     <= 48'd0;
            arg_cnt_q  <= 3'd0;
            timer_q    <= '0;
            status_q   <= 8'd0;
            tx_data_q  <= 8'd0;
            tx_send_q  <= 1'b0;
            tx_owner_q <= 1'b1;
`ifdef PAK_ABORT_EN
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            args_q     <= args_d;
            arg_cnt_q  <= arg_cnt_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            tx_owner_q <= tx_owner_d;
`ifdef PAK_ABORT_EN
            abort_q    <= abort_d;
`endif
        end
    end

    assign reader_start = (state_q == S_LAUNCH);
    assign reader_addr  = addr_q;
    assign reader_count = count_q;
    assign tx_data      = tx_data_q;
    assign tx_send      = tx_send_q;
    assign tx_owner     = tx_owner_q;
    assign busy         = (state_q != S_IDLE);
`ifdef PAK_ABORT_EN
    assign reader_abort = abort_q;
`else
    assign reader_abort = 1'b0;
`endif

endmodule

// File: tb/tb_pak_dump_sequencer.sv
// Randomized self-checking bench for pak_dump_sequencer; the bench plays the read engine and UART.
// Build with PAK_ABORT_EN defined to exercise the abort path instead of the ignore path.

module tb_pak_dump_sequencer;

    localparam int TIMEOUT = 50;
    localparam int HDR     = 96;

    logic        pin_clk = 1'b0;
    logic        pin_rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reader_start;
    logic [23:0] reader_addr;
    logic [23:0] reader_count;
    logic        reader_done;
    logic        reader_abort;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready;
    logic        tx_owner;
    logic        busy;

    int n_checks  = 0;
    int n_errors  = 0;
    int start_cnt = 0;
    int send_cnt  = 0;
    int abort_cnt = 0;
    logic prev_send = 1'b0;

    pak_dump_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .HEADER_WORDS   (HDR)
    ) dut (
        .pin_clk      (pin_clk),
        .pin_rst_n    (pin_rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .reader_start (reader_start),
        .reader_addr  (reader_addr),
        .reader_count (reader_count),
        .reader_done  (reader_done),
        .reader_abort (reader_abort),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_ready     (tx_ready),
        .tx_owner     (tx_owner),
        .busy         (busy)
    );

    initial forever #5 pin_clk = ~pin_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge pin_clk) begin
        if (tx_send) begin
            send_cnt++;
            check("send_back_to_back", 32'(prev_send), 32'd0);
        end
        if (reader_start) start_cnt++;
        if (reader_abort) abort_cnt++;
        prev_send = tx_send;
    end

    // Reference model: words to read for a single-byte dump command, -1 if not a dump command.
    function automatic longint cmd_words(input logic [7:0] c);
        longint mb;
        case (c)
            8'h68:   return longint'(HDR);
            8'h61:   mb = 4;
            8'h62:   mb = 8;
            8'h63:   mb = 16;
            8'h64:   mb = 32;
            default: return -1;
        endcase
        // 16-bit words; the 24-bit count field saturates.
        if ((mb << 20) / 2 > 64'hFF_FFFF) return 64'hFF_FFFF;
        return (mb << 20) / 2;
    endfunction

    function automatic bit range_ok(input longint a, input longint c);
        return (c != 0) && (a + c <= (longint'(1) << 24));
    endfunction

    function automatic logic [7:0] noise_byte();
        logic [7:0] pool [5] = '{8'h61, 8'h3F, 8'h72, 8'h68, 8'h45};
        return pool[$urandom_range(0, 4)];
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge pin_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, 32'(reader_start), 32'd0);
        check({tag, "_addr"},  32'(reader_addr),  32'd0);
        check({tag, "_count"}, 32'(reader_count), 32'd0);
        check({tag, "_abort"}, 32'(reader_abort), 32'd0);
        check({tag, "_txdata"}, 32'(tx_data),     32'd0);
        check({tag, "_txsend"}, 32'(tx_send),     32'd0);
        check({tag, "_owner"}, 32'(tx_owner),     32'd1);
        check({tag, "_busy"},  32'(busy),         32'd0);
    endtask

    // Waits for a status byte; lat counts cycles after the current sample point.
    task automatic wait_send(input string tag, input logic [7:0] exp, input int lat_max, input bit exact);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < lat_max + 3) begin
            tick();
            lat++;
            seen = tx_send;
        end
        check({tag, "_sent"}, 32'(seen), 32'd1);
        if (seen) begin
            if (exact) check({tag, "_send_lat"}, 32'(lat), 32'(lat_max));
            else       check({tag, "_send_late"}, 32'(lat <= lat_max), 32'd1);
            check({tag, "_status"}, 32'(tx_data), 32'(exp));
            check({tag, "_idle"}, 32'(busy), 32'd0);
            tick();
            check({tag, "_send_once"}, 32'(tx_send), 32'd0);
            check({tag, "_data_hold"}, 32'(tx_data), 32'(exp));
        end
    endtask

    task automatic expect_launch(input string tag, input longint ea, input longint ec, input int elat);
        int lat;
        lat = 1;
        while (!reader_start && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, "_start_lat"}, 32'(lat), 32'(elat));
        check({tag, "_addr"},  32'(reader_addr),  32'(ea));
        check({tag, "_count"}, 32'(reader_count), 32'(ec));
        tick();
        check({tag, "_start_pulse"}, 32'(reader_start), 32'd0);
        check({tag, "_owner_wait"},  32'(tx_owner),     32'd0);
        check({tag, "_busy_wait"},   32'(busy),         32'd1);
    endtask

    // Runs the engine side of a burst, then collects the `D` status.
    task automatic finish_burst(input string tag, input longint ea, input longint ec, input int hold);
        int gap;
        int sends0;
        int starts0;
        gap = $urandom_range(0, 8);
        for (int i = 0; i < gap; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                rx_data  = noise_byte();
                rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
        end
        check({tag, "_addr_stable"},  32'(reader_addr),  32'(ea));
        check({tag, "_count_stable"}, 32'(reader_count), 32'(ec));
        tx_ready    = (hold == 0);
        reader_done = 1'b1;
        tick();
        reader_done = 1'b0;
        check({tag, "_owner_resp"}, 32'(tx_owner), 32'd1);
        sends0  = send_cnt;
        starts0 = start_cnt;
        if (hold > 0) begin
            send_byte(8'h61);
            tick(hold - 1);
            check({tag, "_held"}, 32'(send_cnt - sends0), 32'd0);
            tx_ready = 1'b1;
            wait_send(tag, 8'h44, 2, 1'b0);
            tick(3);
            check({tag, "_resp_drop"}, 32'(start_cnt - starts0), 32'd0);
        end else begin
            wait_send(tag, 8'h44, 1, 1'b1);
        end
        check({tag, "_one_send"}, 32'(send_cnt - sends0), 32'd1);
    endtask

    task automatic run_range(input string tag, input longint a, input longint c, input int max_gap, input int hold);
        logic [47:0] args;
        int s0;
        args = {a[23:0], c[23:0]};
        s0   = start_cnt;
        send_byte(8'h72);
        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(0, max_gap));
            send_byte(args[47 - 8 * i -: 8]);
        end
        if (range_ok(a, c)) begin
            expect_launch(tag, a, c, 2);
            finish_burst(tag, a, c, hold);
        end else begin
            wait_send(tag, 8'h45, 2, 1'b0);
            check({tag, "_no_start"}, 32'(start_cnt - s0), 32'd0);
        end
    endtask

    task automatic run_truncated(input string tag, input int nbytes);
        int s0;
        s0 = start_cnt;
        send_byte(8'h72);
        for (int i = 0; i < nbytes; i++) begin
            tick($urandom_range(0, TIMEOUT - 1));
            send_byte(8'($urandom_range(0, 255)));
        end
        tick(TIMEOUT - 2);
        check({tag, "_not_early"}, 32'(busy), 32'd1);
        wait_send(tag, 8'h54, 6, 1'b0);
        check({tag, "_no_start"}, 32'(start_cnt - s0), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        longint a;
        longint c;
        int     s0;
        int     a0;
        logic [7:0] b;
        logic [7:0] dump_cmds [5] = '{8'h68, 8'h61, 8'h62, 8'h63, 8'h64};

        pin_rst_n   = 1'b0;
        rx_data     = 8'd0;
        rx_valid    = 1'b0;
        reader_done = 1'b0;
        tx_ready    = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        pin_rst_n = 1'b1;
        tick();

        send_byte(8'h68);
        expect_launch("hdr", 0, cmd_words(8'h68), 1);
        finish_burst("hdr", 0, cmd_words(8'h68), 0);

        run_range("rng", 64'h01_0000, 64'h10, 0, 0);
        run_range("ovf", 64'hFF_FFF0, 64'h20, 3, 0);
        run_range("zero", 0, 0, 3, 0);
        run_range("top_edge", 64'hFF_FF00, 64'h100, TIMEOUT - 1, 0);
        run_range("past_top", 64'hFF_FF00, 64'h101, 2, 0);

        s0 = start_cnt;
        send_byte(8'h72);
        send_byte(8'h00);
        send_byte(8'h12);
        tick(TIMEOUT - 2);
        check("to_not_early", 32'(busy), 32'd1);
        wait_send("to", 8'h54, 6, 1'b0);
        check("to_no_start", 32'(start_cnt - s0), 32'd0);
        send_byte(8'h61);
        expect_launch("after_to", 0, cmd_words(8'h61), 1);
        finish_burst("after_to", 0, cmd_words(8'h61), 0);

        send_byte(8'h62);
        expect_launch("hold", 0, cmd_words(8'h62), 1);
        finish_burst("hold", 0, cmd_words(8'h62), 20);

        send_byte(8'h3F);
        wait_send("query", 8'h4B, 1, 1'b1);

        // Done and an rx byte in the same WAIT cycle: done wins, byte dropped.
        send_byte(8'h64);
        expect_launch("race", 0, cmd_words(8'h64), 1);
        tick(2);
        a0 = abort_cnt;
        s0 = start_cnt;
        rx_data     = 8'h78;
        rx_valid    = 1'b1;
        reader_done = 1'b1;
        tick();
        rx_valid    = 1'b0;
        reader_done = 1'b0;
        wait_send("race", 8'h44, 1, 1'b1);
        tick(3);
        check("race_no_abort", 32'(abort_cnt - a0), 32'd0);
        check("race_no_start", 32'(start_cnt - s0), 32'd0);

        send_byte(8'h63);
        expect_launch("xmid", 0, cmd_words(8'h63), 1);
        tick(3);
        a0 = abort_cnt;
        send_byte(8'h78);
`ifdef PAK_ABORT_EN
        check("xmid_abort", 32'(reader_abort), 32'd1);
        check("xmid_owner", 32'(tx_owner), 32'd1);
        wait_send("xmid", 8'h41, 1, 1'b1);
        s0 = send_cnt;
        reader_done = 1'b1;
        tick();
        reader_done = 1'b0;
        tick(5);
        check("xmid_late_done", 32'(send_cnt - s0), 32'd0);
        check("xmid_idle", 32'(busy), 32'd0);
        check("xmid_one_abort", 32'(abort_cnt - a0), 32'd1);
`else
        check("xign_busy", 32'(busy), 32'd1);
        check("xign_owner", 32'(tx_owner), 32'd0);
        s0 = send_cnt;
        tick(3);
        check("xign_no_send", 32'(send_cnt - s0), 32'd0);
        finish_burst("xign", 0, cmd_words(8'h63), 0);
        check("xign_no_abort", 32'(abort_cnt - a0), 32'd0);
`endif

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 8))
                0, 1, 2, 3, 4: begin
                    b = dump_cmds[$urandom_range(0, 4)];
                    send_byte(b);
                    expect_launch("rnd_dump", 0, cmd_words(b), 1);
                    finish_burst("rnd_dump", 0, cmd_words(b),
                                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
                end
                5: begin
                    send_byte(8'h3F);
                    wait_send("rnd_query", 8'h4B, 1, 1'b1);
                end
                6: begin
                    a = longint'($urandom_range(1, 24'hFF_FFFF));
                    case ($urandom_range(0, 3))
                        0:       c = 0;
                        1:       c = longint'($urandom_range(0, 24'hFF_FFFF));
                        2:       c = 1 + longint'($urandom) % ((longint'(1) << 24) - a);
                        default: c = (longint'(1) << 24) - a;
                    endcase
                    run_range("rnd_rng", a, c, TIMEOUT - 1,
                              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
                end
                7: begin
                    do b = 8'($urandom_range(0, 255));
                    while (cmd_words(b) >= 0 || b == 8'h72 || b == 8'h3F);
                    s0 = start_cnt;
                    a0 = send_cnt;
                    send_byte(b);
                    tick(2);
                    check("rnd_junk_idle", 32'(busy), 32'd0);
                    check("rnd_junk_quiet", 32'((start_cnt - s0) + (send_cnt - a0)), 32'd0);
                end
                default: run_truncated("rnd_trunc", $urandom_range(0, 5));
            endcase
        end

        // Reset in the middle of a burst: outputs return to reset values, nothing is reported.
        send_byte(8'h61);
        expect_launch("rst_mid", 0, cmd_words(8'h61), 1);
        tick(2);
        pin_rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        pin_rst_n = 1'b1;
        s0 = send_cnt;
        a0 = abort_cnt;
        reader_done = 1'b1;
        tick();
        reader_done = 1'b0;
        tick(8);
        check("rst_mid_no_send", 32'(send_cnt - s0), 32'd0);
        check("rst_mid_no_abort", 32'(abort_cnt - a0), 32'd0);
        check("rst_mid_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
